// File: rtl/wb_sequencer_if.sv
// Instruction handshake, data-memory handshake and writeback control bundle
// between the decode/memory side and the writeback sequencer.
interface wb_sequencer_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [1:0]                instr_type;
  logic [REG_ADDR_WIDTH-1:0] rd_in;
  logic                      mem_req;
  logic                      mem_ack;
  logic [1:0]                result_sel;
  logic                      reg_write;
  logic [REG_ADDR_WIDTH-1:0] rd_out;
  logic                      pc_en;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    output instr_valid, instr_type, rd_in, mem_ack,
    input  instr_ready, mem_req, result_sel, reg_write, rd_out, pc_en, busy, timeout_err
  );

  modport slave (
    input  instr_valid, instr_type, rd_in, mem_ack,
    output instr_ready, mem_req, result_sel, reg_write, rd_out, pc_en, busy, timeout_err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one decoded instruction, waits for memory when
// needed, then drives the writeback mux select, register-file write and PC advance.
module wb_sequencer #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CNT_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB, S_DONE} state_e;

  localparam logic [1:0] T_ALU  = 2'b00;
  localparam logic [1:0] T_LOAD = 2'b01;
  localparam logic [1:0] T_JUMP = 2'b10;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [1:0]                type_q, type_d;
  logic [1:0]                sel_q, sel_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      terr_q, terr_d;

  logic                      ready_q, ready_d;
  logic                      mem_req_q, mem_req_d;
  logic [1:0]                result_sel_q, result_sel_d;
  logic                      reg_write_q, reg_write_d;
  logic                      pc_en_q, pc_en_d;
  logic                      busy_q, busy_d;

  // State, latched fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      type_q       <= 2'b00;
      sel_q        <= SEL_ALU;
      rd_q         <= '0;
      cnt_q        <= '0;
      terr_q       <= 1'b0;
      ready_q      <= 1'b1;
      mem_req_q    <= 1'b0;
      result_sel_q <= SEL_ALU;
      reg_write_q  <= 1'b0;
      pc_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
      ready_q      <= ready_d;
      mem_req_q    <= mem_req_d;
      result_sel_q <= result_sel_d;
      reg_write_q  <= reg_write_d;
      pc_en_q      <= pc_en_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; an ack in the final MEM cycle beats the timeout
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          type_d = bus.instr_type;
          rd_d   = bus.rd_in;
          cnt_d  = '0;
          unique case (bus.instr_type)
            T_ALU: begin
              sel_d   = SEL_ALU;
              state_d = S_WB;
            end
            T_JUMP: begin
              sel_d   = SEL_PC;
              state_d = S_WB;
            end
            default: state_d = S_MEM;
          endcase
        end
      end
      S_MEM: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (bus.mem_ack) begin
          if (type_q == T_LOAD) begin
            sel_d   = SEL_MEM;
            state_d = S_WB;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    ready_d      = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_MEM);
    busy_d       = (state_d != S_IDLE);
    result_sel_d = (state_d == S_WB) ? sel_d : SEL_ALU;
    reg_write_d  = (state_d == S_WB) && (rd_d != '0);
    pc_en_d      = (state_d == S_WB) || (state_d == S_DONE);
  end

  assign bus.instr_ready = ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.result_sel  = result_sel_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.rd_out      = rd_q;
  assign bus.pc_en       = pc_en_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomised bench for wb_sequencer: each instruction is expanded into its
// expected per-cycle output sequence and compared on every falling edge.
module tb_wb_sequencer;
  localparam int T = 15;
  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, JUMP = 2'b10, STORE = 2'b11;

  typedef struct packed {
    logic       rdy;
    logic       mreq;
    logic [1:0] sel;
    logic       rw;
    logic [4:0] rd;
    logic       pc;
    logic       busy;
    logic       terr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  obs_t exp_q[$];
  obs_t cur, fin;
  logic [4:0] exp_rd = '0;
  logic       exp_terr = 1'b0;
  int         memreq_cnt;

  wb_sequencer_if #(.REG_ADDR_WIDTH(5)) bus ();

  wb_sequencer #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(T), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.rdy  = bus.instr_ready;
    o.mreq = bus.mem_req;
    o.sel  = bus.result_sel;
    o.rw   = bus.reg_write;
    o.rd   = bus.rd_out;
    o.pc   = bus.pc_en;
    o.busy = bus.busy;
    o.terr = bus.timeout_err;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rdy=%0b mreq=%0b sel=%0d rw=%0b rd=%0d pc=%0b busy=%0b terr=%0b",
                     o.rdy, o.mreq, o.sel, o.rw, o.rd, o.pc, o.busy, o.terr);
  endfunction

  // Model: what the outputs must look like in each phase of an instruction
  function automatic obs_t rec(logic rdy, logic mreq, logic [1:0] sel, logic rw, logic pc);
    obs_t o;
    o.rdy = rdy; o.mreq = mreq; o.sel = sel; o.rw = rw; o.pc = pc;
    o.busy = ~rdy; o.rd = exp_rd; o.terr = exp_terr;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t actual{%s} required{%s}", $time, fmt(a), fmt(e));
      end
    end
  end

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] ty, input logic [4:0] rd,
                      input logic ack, input obs_t e);
    @(posedge clk);
    #1;
    bus.instr_valid = v;
    bus.instr_type  = ty;
    bus.rd_in       = rd;
    bus.mem_ack     = ack;
    exp_q.push_back(e);
    #1;
    cur = sample();
  endtask

  task automatic idle_step();
    step(1'b0, 2'($urandom), 5'($urandom), 1'($urandom), rec(1, 0, 2'b00, 0, 0));
  endtask

  // k = MEM cycle index carrying mem_ack; k >= T means memory never answers
  task automatic do_instr(input logic [1:0] ty, input logic [4:0] rd, input int k, input int idle_n);
    int n;
    $display("txn type=%0d rd=%0d ack_at=%0d idle=%0d", ty, rd, k, idle_n);
    for (int i = 0; i < idle_n; i++) idle_step();
    step(1'b1, ty, rd, 1'($urandom), rec(1, 0, 2'b00, 0, 0));
    exp_rd = rd;
    memreq_cnt = 0;
    if (ty == ALU || ty == JUMP) begin
      step(1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom),
           rec(0, 0, (ty == JUMP) ? 2'b10 : 2'b00, rd != 0, 1));
    end else begin
      n = (k < T) ? k + 1 : T;
      for (int j = 0; j < n; j++) begin
        step(1'($urandom), 2'($urandom), 5'($urandom), (j == k), rec(0, 1, 2'b00, 0, 0));
        memreq_cnt += int'(cur.mreq);
      end
      if (k >= T) exp_terr = 1'b1;
      if (k < T && ty == LOAD)
        step(1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), rec(0, 0, 2'b01, rd != 0, 1));
      else
        step(1'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), rec(0, 0, 2'b00, 0, 1));
    end
    fin = cur;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_type  = 2'b00;
    bus.rd_in       = '0;
    bus.mem_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cur = sample();
    lit("reset_ready", cur.rdy, 1);
    lit("reset_quiet", {cur.mreq, cur.sel, cur.rw, cur.rd, cur.pc, cur.busy, cur.terr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_instr(ALU, 5'd5, 0, 1);
    lit("alu_sel", fin.sel, 0); lit("alu_rw", fin.rw, 1);
    lit("alu_rd", fin.rd, 5);   lit("alu_pc", fin.pc, 1);
    idle_step();
    lit("alu_ready_after", cur.rdy, 1); lit("alu_rw_after", cur.rw, 0);

    do_instr(LOAD, 5'd10, 3, 0);
    lit("load_memreq_cycles", memreq_cnt, 4);
    lit("load_sel", fin.sel, 1); lit("load_rw", fin.rw, 1);
    lit("load_rd", fin.rd, 10);  lit("load_pc", fin.pc, 1);

    do_instr(JUMP, 5'd0, 0, 1);
    lit("jump_x0_sel", fin.sel, 2); lit("jump_x0_pc", fin.pc, 1); lit("jump_x0_rw", fin.rw, 0);

    do_instr(STORE, 5'd12, 0, 1);
    lit("store_pc", fin.pc, 1); lit("store_rw", fin.rw, 0); lit("store_ready_in_done", fin.rdy, 0);
    idle_step();
    lit("store_ready_after", cur.rdy, 1);

    do_instr(LOAD, 5'd3, 99, 1);
    lit("timeout_memreq_cycles", memreq_cnt, 15);
    lit("timeout_err", fin.terr, 1); lit("timeout_pc", fin.pc, 1); lit("timeout_rw", fin.rw, 0);
    do_instr(ALU, 5'd4, 0, 1);
    lit("timeout_sticky", fin.terr, 1); lit("sticky_alu_rw", fin.rw, 1);

    // Asynchronous reset in the middle of a pending LOAD
    do_instr(ALU, 5'd1, 0, 1);
    step(1'b1, LOAD, 5'd7, 1'b0, rec(1, 0, 2'b00, 0, 0));
    exp_rd = 5'd7;
    step(1'b0, 2'b00, 5'd0, 1'b0, rec(0, 1, 2'b00, 0, 0));
    step(1'b0, 2'b00, 5'd0, 1'b0, rec(0, 1, 2'b00, 0, 0));
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    cur = sample();
    lit("rst_mid_memreq", cur.mreq, 0); lit("rst_mid_busy", cur.busy, 0);
    lit("rst_mid_ready", cur.rdy, 1);   lit("rst_mid_terr", cur.terr, 0);
    lit("rst_mid_rw_pc", {cur.rw, cur.pc}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_rd = '0;
    exp_terr = 1'b0;
    repeat (3) begin
      idle_step();
      lit("post_rst_no_write", {cur.rw, cur.pc, cur.busy}, 0);
    end

    do_instr(LOAD, 5'd9, 14, 0);
    lit("ack_on_last_memreq", memreq_cnt, 15);
    lit("ack_on_last_sel", fin.sel, 1); lit("ack_on_last_rw", fin.rw, 1);
    lit("ack_on_last_terr", fin.terr, 0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] ty;
      logic [4:0] rd;
      ty = 2'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_instr(ty, rd, int'($urandom_range(0, 18)), int'($urandom_range(0, 2)));
    end
    repeat (2) idle_step();
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
